// File: rtl/dco_sar_calibrator.sv
// Successive-approximation DCO coarse-code calibrator: binary-searches the
// largest code whose windowed DCO edge count does not exceed the target.
`timescale 1ns/1ps
module dco_sar_calibrator #(
   parameter int CODE_W        = 6,
   parameter int SETTLE_CYCLES = 8,
   parameter int GUARD_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cal_start,
   input  logic [14:0]       target_count,
   input  logic [14:0]       count_untill,
   input  logic [14:0]       compared_count,
   output logic              calibration_mode,
   output logic              clk_count_start,
   output logic [CODE_W-1:0] dco_code,
   output logic              cal_busy,
   output logic              cal_done,
   output logic [14:0]       last_count
);

   localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(1 << (CODE_W - 1));
   localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(CODE_W - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;

   state_t            state;
   state_t            next_state;
   logic [IDX_W-1:0]  idx;
   logic [15:0]       cnt;
   logic [14:0]       target_q;
   logic [14:0]       untill_q;
   logic              settle_last;
   logic              window_last;
   logic              last_bit;
   logic [CODE_W-1:0] bit_mask;
   logic [CODE_W-1:0] decided_code;

   // The window counter is 16 bits so count_untill + GUARD_CYCLES never wraps.
   assign settle_last = (cnt == 16'(SETTLE_CYCLES - 1));
   assign window_last = (cnt == ({1'b0, untill_q} + 16'(GUARD_CYCLES - 1)));
   assign last_bit    = (idx == '0);
   assign bit_mask    = CODE_W'(1) << idx;

   always_comb begin
      decided_code = dco_code;
      if (compared_count > target_q) begin
         decided_code = decided_code & ~bit_mask;
      end
      if (!last_bit) begin
         decided_code = decided_code | (bit_mask >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (cal_start) next_state = SETTLE;
         SETTLE:  if (settle_last) next_state = MEASURE;
         MEASURE: if (window_last) next_state = DECIDE;
         DECIDE:  next_state = last_bit ? IDLE : SETTLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cal_busy         = (state != IDLE);
      calibration_mode = (state != IDLE);
      clk_count_start  = (state == MEASURE) || (state == DECIDE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dco_code   <= MID_CODE;
         idx        <= TOP_IDX;
         cnt        <= '0;
         target_q   <= '0;
         untill_q   <= '0;
         cal_done   <= 1'b0;
         last_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cal_start) begin
                  target_q <= target_count;
                  untill_q <= count_untill;
                  dco_code <= MID_CODE;
                  idx      <= TOP_IDX;
                  cnt      <= '0;
                  cal_done <= 1'b0;
               end
            end
            SETTLE: begin
               cnt <= settle_last ? 16'd0 : cnt + 16'd1;
            end
            MEASURE: begin
               cnt <= cnt + 16'd1;
            end
            DECIDE: begin
               last_count <= compared_count;
               dco_code   <= decided_code;
               cnt        <= '0;
               if (last_bit) begin
                  cal_done <= 1'b1;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dco_sar_calibrator.sv
// Directed bench for dco_sar_calibrator with a linear DCO count model
// (count = 3*code, optionally +5) active only while clk_count_start is high.
`timescale 1ns/1ps
module tb_dco_sar_calibrator;

   logic        clk;
   logic        rst;
   logic        cal_start;
   logic [14:0] target_count;
   logic [14:0] count_untill;
   logic [14:0] compared_count;
   logic        calibration_mode;
   logic        clk_count_start;
   logic [5:0]  dco_code;
   logic        cal_busy;
   logic        cal_done;
   logic [14:0] last_count;

   int          errors;
   int          checks;
   logic        model_offset;
   logic [5:0]  tried [0:7];
   int          n_tried;
   int          high_cycles;

   dco_sar_calibrator dut (
      .clk(clk), .rst(rst), .cal_start(cal_start), .target_count(target_count),
      .count_untill(count_untill), .compared_count(compared_count),
      .calibration_mode(calibration_mode), .clk_count_start(clk_count_start),
      .dco_code(dco_code), .cal_busy(cal_busy), .cal_done(cal_done),
      .last_count(last_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      compared_count = '0;
      if (clk_count_start) begin
         compared_count = ({9'd0, dco_code} * 15'd3) + (model_offset ? 15'd5 : 15'd0);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic start_cal(input logic [14:0] t, input logic [14:0] u);
      @(negedge clk);
      cal_start    = 1'b1;
      target_count = t;
      count_untill = u;
      @(posedge clk);
      #1;
      cal_start = 1'b0;
   endtask

   // Waits for cal_done, recording the code of each window and the
   // number of cycles clk_count_start was high; optionally disturbs inputs.
   task automatic wait_done(input int limit, input bit disturb, output int cycles);
      logic prev;
      prev        = clk_count_start;
      cycles      = 0;
      n_tried     = 0;
      high_cycles = 0;
      while (cal_done !== 1'b1 && cycles < limit) begin
         @(posedge clk);
         #1;
         cycles++;
         if (clk_count_start && !prev && n_tried < 8) begin
            tried[n_tried] = dco_code;
            n_tried++;
         end
         if (clk_count_start) high_cycles++;
         prev = clk_count_start;
         if (disturb) begin
            if (cycles == 250) begin
               cal_start    = 1'b1;
               target_count = 15'd0;
               count_untill = 15'd5;
            end
            if (cycles == 251) cal_start = 1'b0;
            if (cycles == 677) cal_start = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      checks++; if (dco_code !== 6'd32) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 32", dco_code); end
      checks++; if (cal_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", cal_busy); end
      checks++; if (cal_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", cal_done); end
      checks++; if (calibration_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode: got %b expected 0", calibration_mode); end
      checks++; if (clk_count_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_ccs: got %b expected 0", clk_count_start); end
      checks++; if (last_count !== 15'd0) begin errors++; $display("[TB] FAIL reset_last: got %0d expected 0", last_count); end
   endtask

   task automatic test_nominal;
      int cyc;
      logic [5:0] exp_tried [0:5];
      exp_tried = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd34, 6'd33};
      model_offset = 1'b0;
      start_cal(15'd100, 15'd100);
      checks++; if (cal_busy !== 1'b1 || calibration_mode !== 1'b1) begin errors++; $display("[TB] FAIL nom_start_busy: got busy=%b mode=%b expected 1", cal_busy, calibration_mode); end
      wait_done(2000, 1'b0, cyc);
      checks++; if (cyc !== 678) begin errors++; $display("[TB] FAIL nom_latency: got %0d expected 678", cyc); end
      checks++; if (dco_code !== 6'd33) begin errors++; $display("[TB] FAIL nom_code: got %0d expected 33", dco_code); end
      checks++; if (last_count !== 15'd99) begin errors++; $display("[TB] FAIL nom_last: got %0d expected 99", last_count); end
      checks++; if (cal_busy !== 1'b0 || calibration_mode !== 1'b0) begin errors++; $display("[TB] FAIL nom_end_busy: got busy=%b mode=%b expected 0", cal_busy, calibration_mode); end
      checks++; if (n_tried !== 6) begin errors++; $display("[TB] FAIL nom_windows: got %0d expected 6", n_tried); end
      for (int i = 0; i < 6; i++) begin
         checks++; if (tried[i] !== exp_tried[i]) begin errors++; $display("[TB] FAIL nom_tried[%0d]: got %0d expected %0d", i, tried[i], exp_tried[i]); end
      end
      checks++; if (high_cycles !== 630) begin errors++; $display("[TB] FAIL nom_ccs_cycles: got %0d expected 630", high_cycles); end
   endtask

   task automatic test_extremes;
      int cyc;
      model_offset = 1'b1;
      start_cal(15'd0, 15'd100);
      wait_done(2000, 1'b0, cyc);
      checks++; if (dco_code !== 6'd0) begin errors++; $display("[TB] FAIL ext_zero_code: got %0d expected 0", dco_code); end
      checks++; if (last_count !== 15'd8) begin errors++; $display("[TB] FAIL ext_zero_last: got %0d expected 8", last_count); end
      model_offset = 1'b0;
      start_cal(15'd32767, 15'd100);
      wait_done(2000, 1'b0, cyc);
      checks++; if (dco_code !== 6'd63) begin errors++; $display("[TB] FAIL ext_max_code: got %0d expected 63", dco_code); end
      checks++; if (last_count !== 15'd189) begin errors++; $display("[TB] FAIL ext_max_last: got %0d expected 189", last_count); end
      start_cal(15'd96, 15'd100);
      wait_done(2000, 1'b0, cyc);
      checks++; if (dco_code !== 6'd32) begin errors++; $display("[TB] FAIL ext_equal_code: got %0d expected 32", dco_code); end
      checks++; if (cyc !== 678) begin errors++; $display("[TB] FAIL ext_equal_latency: got %0d expected 678", cyc); end
   endtask

   task automatic test_window_zero;
      int cyc;
      model_offset = 1'b0;
      start_cal(15'd100, 15'd0);
      wait_done(500, 1'b0, cyc);
      checks++; if (cyc !== 78) begin errors++; $display("[TB] FAIL win0_latency: got %0d expected 78", cyc); end
      checks++; if (high_cycles !== 30) begin errors++; $display("[TB] FAIL win0_ccs_cycles: got %0d expected 30", high_cycles); end
      checks++; if (dco_code !== 6'd33) begin errors++; $display("[TB] FAIL win0_code: got %0d expected 33", dco_code); end
   endtask

   task automatic test_window_max;
      int wait_cyc;
      int run;
      model_offset = 1'b0;
      start_cal(15'd100, 15'd32767);
      wait_cyc = 0;
      while (clk_count_start !== 1'b1 && wait_cyc < 20) begin
         @(posedge clk); #1; wait_cyc++;
      end
      checks++; if (wait_cyc !== 8) begin errors++; $display("[TB] FAIL winmax_settle: got %0d expected 8", wait_cyc); end
      run = 0;
      while (clk_count_start === 1'b1 && run < 40000) begin
         @(posedge clk); #1; run++;
      end
      checks++; if (run !== 32772) begin errors++; $display("[TB] FAIL winmax_window: got %0d expected 32772", run); end
      checks++; if (dco_code !== 6'd48) begin errors++; $display("[TB] FAIL winmax_next_code: got %0d expected 48", dco_code); end
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_handshake;
      int cyc;
      model_offset = 1'b0;
      start_cal(15'd100, 15'd100);
      wait_done(2000, 1'b1, cyc);
      cal_start = 1'b0;
      target_count = 15'd100;
      count_untill = 15'd100;
      checks++; if (cyc !== 678) begin errors++; $display("[TB] FAIL hs_latency: got %0d expected 678", cyc); end
      checks++; if (dco_code !== 6'd33) begin errors++; $display("[TB] FAIL hs_code: got %0d expected 33", dco_code); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cal_busy !== 1'b0 || cal_done !== 1'b1) begin errors++; $display("[TB] FAIL hs_no_restart: got busy=%b done=%b expected busy=0 done=1", cal_busy, cal_done); end
   endtask

   task automatic test_reset_mid;
      int cyc;
      model_offset = 1'b0;
      start_cal(15'd100, 15'd100);
      repeat (359) @(posedge clk);
      #3;
      checks++; if (clk_count_start !== 1'b1 || dco_code !== 6'd36) begin errors++; $display("[TB] FAIL rstmid_pre: got ccs=%b code=%0d expected ccs=1 code=36", clk_count_start, dco_code); end
      rst = 1'b1;
      #1;
      checks++; if (dco_code !== 6'd32) begin errors++; $display("[TB] FAIL rstmid_code: got %0d expected 32", dco_code); end
      checks++; if (cal_busy !== 1'b0 || calibration_mode !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got busy=%b mode=%b expected 0", cal_busy, calibration_mode); end
      checks++; if (clk_count_start !== 1'b0 || cal_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ccs_done: got ccs=%b done=%b expected 0", clk_count_start, cal_done); end
      checks++; if (last_count !== 15'd0) begin errors++; $display("[TB] FAIL rstmid_last: got %0d expected 0", last_count); end
      @(negedge clk); rst = 1'b0;
      start_cal(15'd100, 15'd100);
      wait_done(2000, 1'b0, cyc);
      checks++; if (cyc !== 678 || dco_code !== 6'd33) begin errors++; $display("[TB] FAIL rstmid_rerun: got cycles=%0d code=%0d expected 678/33", cyc, dco_code); end
   endtask

   task automatic test_restart;
      int cyc;
      checks++; if (cal_done !== 1'b1) begin errors++; $display("[TB] FAIL restart_pre_done: got %b expected 1", cal_done); end
      start_cal(15'd32767, 15'd10);
      checks++; if (cal_done !== 1'b0) begin errors++; $display("[TB] FAIL restart_done_clear: got %b expected 0", cal_done); end
      checks++; if (dco_code !== 6'd32 || cal_busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_mid: got code=%0d busy=%b expected 32/1", dco_code, cal_busy); end
      wait_done(2000, 1'b0, cyc);
      checks++; if (cyc !== 138 || dco_code !== 6'd63) begin errors++; $display("[TB] FAIL restart_result: got cycles=%0d code=%0d expected 138/63", cyc, dco_code); end
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      cal_start    = 1'b0;
      target_count = '0;
      count_untill = '0;
      model_offset = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b0;
      test_nominal;
      test_extremes;
      test_window_zero;
      test_window_max;
      test_handshake;
      test_reset_mid;
      test_restart;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
